// File: rtl/ysyx_pkg.sv
// Shared widths and ALU function codes for the RV32I execute-stage datapath.
// Codes follow {funct7[5], funct3}, with COPYB taking an otherwise unused slot for LUI.
package ysyx_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned NUM_REGS = 1 << REG_AW;
    localparam int unsigned FUNC_W   = 4;

    localparam logic [FUNC_W-1:0] ALU_ADD   = 4'b0000;
    localparam logic [FUNC_W-1:0] ALU_SUB   = 4'b1000;
    localparam logic [FUNC_W-1:0] ALU_SLL   = 4'b0001;
    localparam logic [FUNC_W-1:0] ALU_SLT   = 4'b0010;
    localparam logic [FUNC_W-1:0] ALU_SLTU  = 4'b0011;
    localparam logic [FUNC_W-1:0] ALU_XOR   = 4'b0100;
    localparam logic [FUNC_W-1:0] ALU_SRL   = 4'b0101;
    localparam logic [FUNC_W-1:0] ALU_SRA   = 4'b1101;
    localparam logic [FUNC_W-1:0] ALU_OR    = 4'b0110;
    localparam logic [FUNC_W-1:0] ALU_AND   = 4'b0111;
    localparam logic [FUNC_W-1:0] ALU_COPYB = 4'b1111;

endpackage

// File: rtl/ysyx_alu_regfile_if.sv
// Register-file ports and ALU operands/result bundled for the execute stage.
// The master drives indices, write data and operands; the slave returns read data and ALUout.
interface ysyx_alu_regfile_if;
    import ysyx_pkg::*;

    logic              rf_wr_en;
    logic [REG_AW-1:0] waddr;
    logic [XLEN-1:0]   wdata;
    logic [REG_AW-1:0] raddr1;
    logic [REG_AW-1:0] raddr2;
    logic [XLEN-1:0]   rdata1;
    logic [XLEN-1:0]   rdata2;
    logic [XLEN-1:0]   SrcA;
    logic [XLEN-1:0]   SrcB;
    logic [FUNC_W-1:0] func;
    logic [XLEN-1:0]   ALUout;

    modport master (
        output rf_wr_en, waddr, wdata, raddr1, raddr2, SrcA, SrcB, func,
        input  rdata1, rdata2, ALUout
    );

    modport slave (
        input  rf_wr_en, waddr, wdata, raddr1, raddr2, SrcA, SrcB, func,
        output rdata1, rdata2, ALUout
    );

endinterface

// File: rtl/ysyx_alu.sv
// Purely combinational RV32I ALU; shifts use only src_b[4:0], unknown codes yield zero.
module ysyx_alu
    import ysyx_pkg::*;
(
    input  logic [XLEN-1:0]   src_a,
    input  logic [XLEN-1:0]   src_b,
    input  logic [FUNC_W-1:0] func,
    output logic [XLEN-1:0]   alu_out
);

    logic [4:0] shamt;

    assign shamt = src_b[4:0];

    always_comb begin
        alu_out = '0;
        case (func)
            ALU_ADD:   alu_out = src_a + src_b;
            ALU_SUB:   alu_out = src_a - src_b;
            ALU_SLL:   alu_out = src_a << shamt;
            ALU_SLT:   alu_out = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            ALU_SLTU:  alu_out = {{(XLEN-1){1'b0}}, src_a < src_b};
            ALU_XOR:   alu_out = src_a ^ src_b;
            ALU_SRL:   alu_out = src_a >> shamt;
            ALU_SRA:   alu_out = $unsigned($signed(src_a) >>> shamt);
            ALU_OR:    alu_out = src_a | src_b;
            ALU_AND:   alu_out = src_a & src_b;
            ALU_COPYB: alu_out = src_b;
            default:   alu_out = '0;
        endcase
    end

endmodule

// File: rtl/ysyx_alu_regfile.sv
// 32x32 register file (two combinational reads, one clocked write, x0 hardwired to zero)
// alongside the execute-stage ALU.
module ysyx_alu_regfile
    import ysyx_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    ysyx_alu_regfile_if.slave bus
);

    logic [XLEN-1:0] regs [NUM_REGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (bus.rf_wr_en && (bus.waddr != '0)) begin
            regs[bus.waddr] <= bus.wdata;
        end
    end

    // No write-to-read bypass: a pending write only shows up after the edge.
    always_comb begin
        bus.rdata1 = '0;
        bus.rdata2 = '0;
        if (!rst && (bus.raddr1 != '0)) begin
            bus.rdata1 = regs[bus.raddr1];
        end
        if (!rst && (bus.raddr2 != '0)) begin
            bus.rdata2 = regs[bus.raddr2];
        end
    end

    ysyx_alu u_alu (
        .src_a   (bus.SrcA),
        .src_b   (bus.SrcB),
        .func    (bus.func),
        .alu_out (bus.ALUout)
    );

endmodule

// File: tb/tb_ysyx_alu_regfile.sv
// Directed plus randomized bench for ysyx_alu_regfile against an array/arithmetic model.
module tb_ysyx_alu_regfile;
    import ysyx_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ysyx_alu_regfile_if bus ();

    ysyx_alu_regfile dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [31:0] mdl [32];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] alu_model(input logic [3:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] ext;
        int unsigned sh;
        sh = b % 32;
        case (f)
            4'b0000: return a + b;
            4'b1000: return a + ~b + 32'd1;
            4'b0001: return a * (32'd1 << sh);
            4'b0010: return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            4'b0011: return (a < b) ? 32'd1 : 32'd0;
            4'b0100: return a ^ b;
            4'b0101: return a / (32'd1 << sh);
            4'b1101: begin
                ext = {{32{a[31]}}, a};
                ext = ext >> sh;
                return ext[31:0];
            end
            4'b0110: return a | b;
            4'b0111: return a & b;
            4'b1111: return b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic reg_write(input logic [4:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus.rf_wr_en = 1'b1;
        bus.waddr    = addr;
        bus.wdata    = data;
        @(posedge clk);
        if (addr != 5'd0) mdl[addr] = data;
        #1;
        bus.rf_wr_en = 1'b0;
    endtask

    task automatic alu_chk(input string tag, input logic [3:0] f, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        bus.func = f;
        bus.SrcA = a;
        bus.SrcB = b;
        #1;
        check(tag, bus.ALUout, exp);
    endtask

    initial begin
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [3:0]  f;
        logic [31:0] a;
        logic [31:0] b;

        for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
        bus.rf_wr_en = 1'b0;
        bus.waddr    = 5'd0;
        bus.wdata    = 32'd0;
        bus.raddr1   = 5'd5;
        bus.raddr2   = 5'd31;
        bus.SrcA     = 32'd0;
        bus.SrcB     = 32'd0;
        bus.func     = 4'd0;

        #1;
        check("reset_rdata1", bus.rdata1, 32'd0);
        check("reset_rdata2", bus.rdata2, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Asynchronous reset strikes between edges.
        reg_write(5'd5, 32'hDEAD_BEEF);
        #1;
        check("x5_written", bus.rdata1, 32'hDEAD_BEEF);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_x5", bus.rdata1, 32'd0);
        for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
        #1;
        rst = 1'b0;
        #1;
        check("x5_after_reset", bus.rdata1, 32'd0);

        reg_write(5'd1, 32'h1234_5678);
        reg_write(5'd31, 32'hFFFF_FFFF);
        bus.raddr1 = 5'd1;
        bus.raddr2 = 5'd31;
        #1;
        check("read_x1", bus.rdata1, 32'h1234_5678);
        check("read_x31", bus.rdata2, 32'hFFFF_FFFF);

        @(negedge clk);
        bus.rf_wr_en = 1'b0;
        bus.waddr    = 5'd1;
        bus.wdata    = 32'h0000_00AA;
        @(posedge clk);
        #1;
        check("no_wr_en_x1", bus.rdata1, 32'h1234_5678);

        reg_write(5'd0, 32'h0000_0055);
        bus.raddr1 = 5'd0;
        bus.raddr2 = 5'd0;
        #1;
        check("x0_rd1", bus.rdata1, 32'd0);
        check("x0_rd2", bus.rdata2, 32'd0);

        reg_write(5'd7, 32'h0000_0011);
        @(negedge clk);
        bus.raddr1   = 5'd7;
        bus.raddr2   = 5'd7;
        bus.rf_wr_en = 1'b1;
        bus.waddr    = 5'd7;
        bus.wdata    = 32'h0000_0099;
        #1;
        check("rdw_old_rd1", bus.rdata1, 32'h0000_0011);
        check("rdw_old_rd2", bus.rdata2, 32'h0000_0011);
        @(posedge clk);
        mdl[7] = 32'h0000_0099;
        #1;
        bus.rf_wr_en = 1'b0;
        check("rdw_new_rd1", bus.rdata1, 32'h0000_0099);
        check("rdw_new_rd2", bus.rdata2, 32'h0000_0099);

        alu_chk("add_wrap", 4'b0000, 32'hFFFF_FFFF, 32'd1, 32'd0);
        alu_chk("sub_wrap", 4'b1000, 32'd0, 32'd1, 32'hFFFF_FFFF);
        alu_chk("slt_neg", 4'b0010, 32'h8000_0000, 32'd1, 32'd1);
        alu_chk("sltu_big", 4'b0011, 32'h8000_0000, 32'd1, 32'd0);
        alu_chk("sll_mask", 4'b0001, 32'd1, 32'h21, 32'd2);
        alu_chk("srl_31", 4'b0101, 32'h8000_0000, 32'd31, 32'd1);
        alu_chk("sra_4", 4'b1101, 32'h8000_0000, 32'd4, 32'hF800_0000);
        alu_chk("xor", 4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0);
        alu_chk("or", 4'b0110, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0);
        alu_chk("and", 4'b0111, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
        alu_chk("copyb", 4'b1111, 32'hDEAD_0000, 32'h1234_5000, 32'h1234_5000);
        alu_chk("undef_1010", 4'b1010, 32'h1234_5678, 32'h0000_0001, 32'd0);

        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            we = ($urandom_range(0, 3) != 0);
            wa = 5'($urandom_range(0, 31));
            wd = $urandom;
            bus.rf_wr_en = we;
            bus.waddr    = wa;
            bus.wdata    = wd;
            bus.raddr1   = ($urandom_range(0, 1) != 0) ? wa : 5'($urandom_range(0, 31));
            bus.raddr2   = 5'($urandom_range(0, 31));
            #1;
            check("rand_pre_rd1", bus.rdata1, mdl[bus.raddr1]);
            @(posedge clk);
            if (we && wa != 5'd0) mdl[wa] = wd;
            #1;
            check("rand_post_rd1", bus.rdata1, mdl[bus.raddr1]);
            check("rand_post_rd2", bus.rdata2, mdl[bus.raddr2]);
        end
        bus.rf_wr_en = 1'b0;

        for (int i = 0; i < 80; i++) begin
            f = 4'($urandom_range(0, 15));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            if ($urandom_range(0, 3) == 0) a[31] = 1'b1;
            alu_chk("rand_alu", f, a, b, alu_model(f, a, b));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
